if_id_inst_queue: RTL and testbench
===================================

// Module: if_id_inst_queue
// PURPOSE
//  Instruction buffer between fetch (IMEM read data + PC) and decode (ID). Decouples fetch from ID
//  stalls with a small FIFO of {pc, inst} pairs and a valid/ready handshake on both sides.
//  Its head entry feeds the decode stage and the immediate generator. Drops all entries on a redirect flush.
//  When the queue is empty, it presents a canonical NOP so that decode logic never sees X.
// PARAMETERS
//  DEPTH      4    number of entries; power of two, >= 2
//  PC_WIDTH   32   width of the stored PC
//  NOP_INST   32'h0000_0013   instruction driven on out_inst while out_valid=0 (addi x0,x0,0)
// PORTS
//  clk        in   1         core clock, all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  flush_i    in   1         redirect (branch/jump taken): discard all entries
//  in_valid   in   1         fetch presents a valid instruction
//  in_ready   out  1         queue can accept; = (count != DEPTH)
//  in_inst    in   32        fetched instruction word
//  in_pc      in   PC_WIDTH  PC of in_inst
//  out_valid  out  1         head entry valid for decode
//  out_ready  in   1         decode consumes head this cycle (low = ID stall)
//  out_inst   out  32        head instruction, NOP_INST when !out_valid
//  out_pc     out  PC_WIDTH  head PC, 0 when !out_valid
//  count_o    out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH-entry circular buffer; rd_ptr/wr_ptr are $clog2(DEPTH) bits wide and wrap DEPTH-1 -> 0.
//    count is a separate register.
//  - push = in_valid & in_ready & !flush_i; pop = out_valid & out_ready & !flush_i.
//  - On push: entry[wr_ptr] <= {in_pc,in_inst}; wr_ptr++. On pop: rd_ptr++.
//    count += push - pop; a simultaneous push and pop leaves count unchanged.
//  - in_ready and out_valid are combinational from count only (no combinational in_valid->out_valid path,
//    except in the bypass mode described under CONFIGURATION).
//  - Latency: a pushed entry becomes visible on out_valid in the cycle after the push (1 cycle).
//  - Full (count==DEPTH): in_ready=0. A pop in the same cycle does NOT re-open the queue that cycle.
//  - Empty (count==0): out_valid=0, out_inst=NOP_INST, out_pc=0. out_ready is ignored.
//  - flush_i=1: on the next edge, rd_ptr=wr_ptr=0 and count=0. The same-cycle push and pop are both discarded.
//    flush_i has priority over every other event.
//  - Head stability: while out_valid=1 and out_ready=0, out_inst/out_pc hold constant.
//  - Reset (rst_n=0, at any time, including mid-operation): pointers=0, count=0, so out_valid=0,
//    out_inst=NOP_INST, out_pc=0, in_ready=1, count_o=0. Entry storage is not reset.
//  - No state machine beyond occupancy; ordering is strictly FIFO.
//  - Pushing while in_ready=0 is an upstream protocol error: the instruction is dropped and no state changes.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//    - When count==0 and in_valid=1, the input passes through combinationally: out_valid=1,
//      out_inst=in_inst, out_pc=in_pc.
//    - If out_ready=1 in that cycle, the entry is consumed without being written (count stays 0).
//    - Otherwise it is written as a normal push.
//    - Suppressed when flush_i=1.
//  IFQ_BYPASS_EN undefined: the block is pure registered FIFO with 1-cycle minimum latency.
// TESTING
//  1 Reset: rst_n=0 mid-stream with count=3 -> immediately count_o=0, out_valid=0,
//    out_inst=32'h00000013, in_ready=1.
//  2 Fill: push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count_o=4, in_ready=0,
//    out_pc=0x00 held; 5th push (pc 0x10) is refused.
//  3 Drain/wrap: with the queue full, pop 2 and push 0x10,0x14, then pop all -> out_pc order
//    0x00,0x04,0x08,0x0C,0x10,0x14 across the wrap.
//  4 Simultaneous: count=2, push 0x20 and pop in the same cycle -> count_o stays 2, head advances by one.
//  5 Flush: count=3, flush_i=1 with in_valid=1 (pc 0x40) -> next cycle count_o=0, out_valid=0, 0x40 not stored.
//  6 Bypass (IFQ_BYPASS_EN): empty, in_valid=1 inst 32'h00A00093 pc 0x80, out_ready=1 ->
//    same-cycle out_valid=1, out_inst=32'h00A00093, count_o stays 0.
//    Without the macro: out_valid rises the next cycle.

Source files
------------

// File: rtl/if_id_inst_queue.sv
// Fetch-to-decode instruction queue of {pc, inst} pairs with valid/ready on both sides.
// Optional combinational empty-queue bypass: define IFQ_BYPASS_EN.
module if_id_inst_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_WIDTH = 32,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_inst,
   input  logic [PC_WIDTH-1:0]       in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_inst,
   output logic [PC_WIDTH-1:0]       out_pc,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [31:0]         inst;
   } ifq_entry_t;

   ifq_entry_t       mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             empty;
   logic             byp;
   logic             push_q;
   logic             pop_q;

   assign empty    = (count == '0);
   assign in_ready = (count != FULL);
   assign count_o  = count;

`ifdef IFQ_BYPASS_EN
   assign byp = empty & in_valid & ~flush_i;
`else
   assign byp = 1'b0;
`endif

   // A bypassed entry taken by decode this cycle is never written.
   assign push_q = in_valid & in_ready & ~flush_i & ~(byp & out_ready);
   assign pop_q  = ~empty & out_ready & ~flush_i;

   always_comb begin
      out_valid = 1'b0;
      out_inst  = NOP_INST;
      out_pc    = '0;
      if (!empty) begin
         out_valid = 1'b1;
         out_inst  = mem[rd_ptr].inst;
         out_pc    = mem[rd_ptr].pc;
      end else if (byp) begin
         out_valid = 1'b1;
         out_inst  = in_inst;
         out_pc    = in_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_q) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_q)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_q && !pop_q)      count <= count + CNT_ONE;
         else if (pop_q && !push_q) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_q) mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
   end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed and random checks of if_id_inst_queue against a queue-based reference.
// Build with +define+IFQ_BYPASS_EN to check the bypass configuration.
module tb_if_id_inst_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  count_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t model_q[$];

`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   if_id_inst_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle from a negedge, check outputs, advance the model at posedge.
   task automatic step(input string tag, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic ordy, input logic fl);
      int sz;
      bit byp;
      logic ev;
      logic [31:0] ei, ep;
      in_valid = iv; in_inst = inst; in_pc = pc;
      out_ready = ordy; flush_i = fl;
      #1;
      sz  = model_q.size();
      byp = BYP && sz == 0 && iv && !fl;
      ev  = (sz > 0) || byp;
      ei  = (sz > 0) ? model_q[0].inst : (byp ? inst : NOP);
      ep  = (sz > 0) ? model_q[0].pc : (byp ? pc : 32'h0);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".out_inst"}, 64'(out_inst), 64'(ei));
      check({tag, ".out_pc"}, 64'(out_pc), 64'(ep));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(sz != DEPTH));
      check({tag, ".count_o"}, 64'(count_o), 64'(sz));
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         if (sz > 0 && ordy) void'(model_q.pop_front());
         if (iv && sz < DEPTH && !(byp && ordy))
            model_q.push_back('{pc: pc, inst: inst});
      end
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] drain_exp [6];
      drain_exp[0] = 32'h00; drain_exp[1] = 32'h04; drain_exp[2] = 32'h08;
      drain_exp[3] = 32'h0C; drain_exp[4] = 32'h10; drain_exp[5] = 32'h14;

      // Reset state
      #2;
      check("rst.count", 64'(count_o), 64'd0);
      check("rst.out_inst", 64'(out_inst), 64'(NOP));
      @(negedge clk);
      rst_n = 1'b1;
      idle("post_rst");

      // 1: asynchronous reset mid-stream with three entries
      for (int i = 0; i < 3; i++)
         step("t1.push", 1'b1, 32'h1000_0000 + i, 32'h200 + 4 * i, 1'b0, 1'b0);
      check("t1.pre_count", 64'(count_o), 64'd3);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t1.count", 64'(count_o), 64'd0);
      check("t1.out_valid", 64'(out_valid), 64'd0);
      check("t1.out_inst", 64'(out_inst), 64'h13);
      check("t1.out_pc", 64'(out_pc), 64'd0);
      check("t1.in_ready", 64'(in_ready), 64'd1);
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle("t1.idle");

      // 2: fill with decode stalled, then a refused fifth push
      for (int i = 0; i < 4; i++)
         step("t2.fill", 1'b1, 32'hA000_0000 + i, 32'(4 * i), 1'b0, 1'b0);
      check("t2.count", 64'(count_o), 64'd4);
      check("t2.in_ready", 64'(in_ready), 64'd0);
      step("t2.refuse", 1'b1, 32'hA000_0004, 32'h10, 1'b0, 1'b0);
      check("t2.held_pc", 64'(out_pc), 64'h0);
      check("t2.count_after", 64'(count_o), 64'd4);

      // 3: pop two, refill two across the wrap, drain all in order
      for (int i = 0; i < 2; i++) begin
         check("t3.order", 64'(out_pc), 64'(drain_exp[i]));
         step("t3.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      step("t3.push", 1'b1, 32'hA000_0004, 32'h10, 1'b0, 1'b0);
      step("t3.push", 1'b1, 32'hA000_0005, 32'h14, 1'b0, 1'b0);
      for (int i = 2; i < 6; i++) begin
         check("t3.order", 64'(out_pc), 64'(drain_exp[i]));
         step("t3.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      check("t3.empty", 64'(out_valid), 64'd0);

      // 4: simultaneous push and pop at count 2
      step("t4.push", 1'b1, 32'hB000_0000, 32'h18, 1'b0, 1'b0);
      step("t4.push", 1'b1, 32'hB000_0001, 32'h1C, 1'b0, 1'b0);
      step("t4.both", 1'b1, 32'hB000_0002, 32'h20, 1'b1, 1'b0);
      check("t4.count", 64'(count_o), 64'd2);
      check("t4.head", 64'(out_pc), 64'h1C);
      step("t4.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("t4.tail", 64'(out_pc), 64'h20);
      step("t4.pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // 5: flush with a same-cycle push
      for (int i = 0; i < 3; i++)
         step("t5.push", 1'b1, 32'hC000_0000 + i, 32'h30 + 4 * i, 1'b0, 1'b0);
      step("t5.flush", 1'b1, 32'hC000_0003, 32'h40, 1'b1, 1'b1);
      check("t5.count", 64'(count_o), 64'd0);
      check("t5.out_valid", 64'(out_valid), 64'd0);
      idle("t5.idle");

      // 6: empty queue, decode ready, new instruction arrives
      in_valid = 1'b1; in_inst = 32'h00A0_0093; in_pc = 32'h80;
      out_ready = 1'b1; flush_i = 1'b0;
      #1;
      check("t6.same_valid", 64'(out_valid), 64'(BYP));
      check("t6.same_inst", 64'(out_inst), BYP ? 64'h00A0_0093 : 64'h13);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("t6.next_valid", 64'(out_valid), 64'(!BYP));
      check("t6.next_count", 64'(count_o), BYP ? 64'd0 : 64'd1);
      check("t6.next_pc", 64'(out_pc), BYP ? 64'h0 : 64'h80);
      if (!BYP) model_q.push_back('{pc: 32'h80, inst: 32'h00A0_0093});
      step("t6.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle("t6.idle");

      // Random traffic
      for (int n = 0; n < 400; n++)
         step("rand", 1'($urandom_range(0, 3) != 0), $urandom(),
              $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 24) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
